alu_byte_seq: RTL

ALU_BYTE_SEQ -- requirements
Module: alu_byte_seq

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_byte_seq_alu.sv | 32 +++
 rtl/alu_byte_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-serial ALU sequencer: FSM encoding and ALU oper codes.
// SUB is a + ~b + carry per byte; logic ops and NOTA pass the carry; SHL shifts the carry in.
package alu_seq_pkg;
  localparam int OPER_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [OPER_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OPER_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OPER_W-1:0] OP_AND  = 3'd2;
  localparam logic [OPER_W-1:0] OP_OR   = 3'd3;
  localparam logic [OPER_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OPER_W-1:0] OP_INC  = 3'd5;
  localparam logic [OPER_W-1:0] OP_NOTA = 3'd6;
  localparam logic [OPER_W-1:0] OP_SHL  = 3'd7;
endpackage

// File: rtl/alu_byte_seq_alu.sv
// 8-bit combinational ALU slice with carry in/out, chainable across bytes.
// Zero latency; no flow control.
module alu_byte_seq_alu
  import alu_seq_pkg::*;
(
  input  logic [7:0]        i_a,
  input  logic [7:0]        i_b,
  input  logic [OPER_W-1:0] i_oper,
  input  logic              i_c_in,
  output logic [7:0]        o_sum,
  output logic              o_c_out
);
  logic [8:0] w_ext;

  always_comb begin
    w_ext = '0;
    case (i_oper)
      OP_ADD:  w_ext = {1'b0, i_a} + {1'b0, i_b} + {8'h00, i_c_in};
      OP_SUB:  w_ext = {1'b0, i_a} + {1'b0, ~i_b} + {8'h00, i_c_in};
      OP_AND:  w_ext = {i_c_in, i_a & i_b};
      OP_OR:   w_ext = {i_c_in, i_a | i_b};
      OP_XOR:  w_ext = {i_c_in, i_a ^ i_b};
      OP_INC:  w_ext = {1'b0, i_a} + {8'h00, i_c_in};
      OP_NOTA: w_ext = {i_c_in, ~i_a};
      OP_SHL:  w_ext = {i_a, i_c_in};
      default: w_ext = '0;
    endcase
  end

  assign o_sum   = w_ext[7:0];
  assign o_c_out = w_ext[8];
endmodule

// File: rtl/alu_byte_seq.sv
// Multi-byte ALU operation executed one byte per cycle through a single 8-bit ALU slice.
// done rises NBYTES edges after the start-accepting edge; start is ignored while busy.
module alu_byte_seq
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [OPER_W-1:0]     op,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout
);
  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [OPER_W-1:0] r_op;
  logic              r_carry;
  logic              r_busy;
  logic              r_done;
  logic [W-1:0]      r_result;
  logic              r_cout;

  logic [7:0]        w_a_byte;
  logic [7:0]        w_b_byte;
  logic [7:0]        w_sum;
  logic              w_c_out;

  assign w_a_byte = r_a[8*r_idx +: 8];
  assign w_b_byte = r_b[8*r_idx +: 8];

  alu_byte_seq_alu u_alu (
    .i_a     (w_a_byte),
    .i_b     (w_b_byte),
    .i_oper  (r_op),
    .i_c_in  (r_carry),
    .o_sum   (w_sum),
    .o_c_out (w_c_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_op     <= op;
            r_carry  <= cin;
            r_result <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_result[8*r_idx +: 8] <= w_sum;
          r_carry                <= w_c_out;
          r_idx                  <= r_idx + IDX_W'(1);
          // Final byte: publish carry and free the block in the same edge.
          if (r_idx == IDX_LAST) begin
            r_cout  <= w_c_out;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
endmodule
